load_controller: RTL and testbench

Control FSM for the SHAKE load stage. It accepts a header word and then message words from the upstream valid/ready stream. It sequences the load datapath's control strobes (header capture, buffer shift, padding, block counter) and inserts pure padding words once the message is exhausted. It hands each completed rate block to the permutation stage over a valid/ready handshake and flags the final block.

---
 rtl/load_controller.sv | 120 ++++++++++++
 tb/tb_load_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_controller.sv
// load_controller: control FSM for the SHAKE load stage. It accepts a header and message words,
// strobes the load datapath, inserts padding words and hands rate blocks to the permutation stage.
//
// state   | meaning
// IDLE    | waiting for a header word
// LOAD    | accepting message words into the rate buffer
// PAD     | message exhausted, inserting pure padding words
// HANDOFF | offering the completed rate block downstream
module load_controller (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  output logic ready_in,
  input  logic input_buffer_full,
  input  logic input_size_reached,
  input  logic first_incomplete_input_word,
  input  logic last_input_block,
  output logic control_regs_enable,
  output logic load_enable,
  output logic padding_enable,
  output logic padding_reset,
  output logic input_counter_en,
  output logic input_counter_load,
  output logic block_valid,
  input  logic block_ready,
  output logic block_last,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PAD     = 2'd2,
    HANDOFF = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outputs are forced low while rst is held so the datapath sees no strobes mid-reset.
  always_comb begin
    state_next          = state;
    ready_in            = 1'b0;
    control_regs_enable = 1'b0;
    load_enable         = 1'b0;
    padding_enable      = 1'b0;
    padding_reset       = 1'b0;
    input_counter_en    = 1'b0;
    input_counter_load  = 1'b0;
    block_valid         = 1'b0;
    block_last          = 1'b0;
    busy                = 1'b0;
    if (rst) begin
      state_next = IDLE;
    end else begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          ready_in = 1'b1;
          if (valid_in) begin
            control_regs_enable = 1'b1;
            padding_reset       = 1'b1;
            input_counter_load  = 1'b1;
            state_next          = LOAD;
          end
        end
        LOAD: begin
          // Full takes priority: the status lags the strobes by one cycle.
          if (input_buffer_full) begin
            state_next = HANDOFF;
          end else if (input_size_reached) begin
            state_next = PAD;
          end else begin
            ready_in = 1'b1;
            if (valid_in) begin
              load_enable      = 1'b1;
              input_counter_en = 1'b1;
              padding_enable   = first_incomplete_input_word;
            end
          end
        end
        PAD: begin
          if (input_buffer_full) begin
            state_next = HANDOFF;
          end else begin
            load_enable      = 1'b1;
            padding_enable   = 1'b1;
            input_counter_en = 1'b1;
          end
        end
        HANDOFF: begin
          block_valid = 1'b1;
          block_last  = last_input_block;
          if (block_ready) begin
            input_counter_load = 1'b1;
            if (last_input_block) begin
              state_next = IDLE;
            end else if (input_size_reached) begin
              state_next = PAD;
            end else begin
              state_next = LOAD;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_controller.sv
// Bench for load_controller: a registered datapath model feeds the status inputs, and each message
// is expanded into an expected per-cycle output trace derived from block/word arithmetic.
module tb_load_controller;

  logic clk;
  logic rst;
  logic valid_in;
  logic ready_in;
  logic input_buffer_full;
  logic input_size_reached;
  logic first_incomplete_input_word;
  logic last_input_block;
  logic control_regs_enable;
  logic load_enable;
  logic padding_enable;
  logic padding_reset;
  logic input_counter_en;
  logic input_counter_load;
  logic block_valid;
  logic block_ready;
  logic block_last;
  logic busy;

  load_controller dut (
    .clk                         (clk),
    .rst                         (rst),
    .valid_in                    (valid_in),
    .ready_in                    (ready_in),
    .input_buffer_full           (input_buffer_full),
    .input_size_reached          (input_size_reached),
    .first_incomplete_input_word (first_incomplete_input_word),
    .last_input_block            (last_input_block),
    .control_regs_enable         (control_regs_enable),
    .load_enable                 (load_enable),
    .padding_enable              (padding_enable),
    .padding_reset               (padding_reset),
    .input_counter_en            (input_counter_en),
    .input_counter_load          (input_counter_load),
    .block_valid                 (block_valid),
    .block_ready                 (block_ready),
    .block_last                  (block_last),
    .busy                        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: header fields, word counter, remaining bits, padding-closed flag.
  int   cur_depth = 17;
  int   cur_size  = 0;
  int   cnt       = 0;
  int   rem       = 0;
  logic padflag   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cnt     <= 0;
      rem     <= 0;
      padflag <= 1'b0;
    end else begin
      if (control_regs_enable) rem <= cur_size;
      else if (load_enable)    rem <= (rem > 64) ? rem - 64 : 0;
      if (input_counter_load)    cnt <= 0;
      else if (input_counter_en) cnt <= cnt + 1;
      if (padding_reset)       padflag <= 1'b0;
      else if (padding_enable) padflag <= 1'b1;
    end
  end

  assign input_buffer_full           = (cnt == cur_depth);
  assign input_size_reached          = (rem == 0);
  assign first_incomplete_input_word = (rem > 0) && (rem < 64);
  assign last_input_block            = padflag;

  logic [9:0] outv;
  assign outv = {ready_in, control_regs_enable, load_enable, padding_enable, padding_reset,
                 input_counter_en, input_counter_load, block_valid, block_last, busy};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [9:0] exp_q[$];

  // Driver state
  int phase, words, msg_words, hv, bp_dly, abort_words;
  int pad_cnt, blk_cnt, last_cnt, stall_cnt;

  function automatic logic [9:0] vec(input bit r, input bit cre, input bit le, input bit pe,
                                     input bit pr, input bit ice, input bit icl, input bit bv,
                                     input bit bl, input bit bsy);
    return {r, cre, le, pe, pr, ice, icl, bv, bl, bsy};
  endfunction

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  // Expected trace for a message with valid_in always available and bp stall cycles per handoff.
  task automatic build_trace(input int depth, input int size, input int bp);
    int w, nb, i;
    bit partial;
    w       = (size + 63) / 64;
    partial = (size % 64) != 0;
    // A full final word needs an extra padding word, which may spill into a new block.
    nb = partial ? (w + depth - 1) / depth : w / depth + 1;
    exp_q.push_back(vec(1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < depth; k++) begin
        i = b * depth + k;
        if (i == w && (k != 0 || w == 0))
          exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        if (i < w) exp_q.push_back(vec(1, 0, 1, partial && (i == w - 1), 0, 1, 0, 0, 0, 1));
        else       exp_q.push_back(vec(0, 0, 1, 1, 0, 1, 0, 0, 0, 1));
      end
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      for (int d = 0; d < bp; d++)
        exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 0, 1, b == nb - 1, 1));
      exp_q.push_back(vec(0, 0, 0, 0, 0, 0, 1, 1, b == nb - 1, 1));
    end
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // One clock: compare at negedge, then drive the next cycle's inputs just after posedge.
  task automatic step();
    logic acc, bacc;
    logic [9:0] e;
    @(negedge clk);
    cyc++;
    acc  = valid_in && ready_in;
    bacc = block_valid && block_ready;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (outv !== e) begin
        fails++;
        $display("FAIL trace cycle %0d: got %b want %b", cyc, outv, e);
      end
    end
    if (load_enable && !ready_in) pad_cnt++;
    if (bacc) blk_cnt++;
    if (bacc && block_last) last_cnt++;
    if (block_valid && !block_ready) stall_cnt++;
    @(posedge clk);
    #1;
    if (acc) begin
      if (phase == 0) phase = 1;
      else            words++;
    end
    if (bacc) hv = 0;
    if (rst) begin
      rst = 1'b0;
    end else if (abort_words >= 0 && phase == 1 && words == abort_words) begin
      rst   = 1'b1;
      phase = 2;
    end
    valid_in = !rst && (phase == 0 || (phase == 1 && words < msg_words));
    if (block_valid) begin
      block_ready = (hv >= bp_dly);
      hv++;
    end else begin
      block_ready = 1'b0;
    end
  endtask

  task automatic run_msg(input int depth, input int size, input int bp, input int abort);
    int n;
    cur_depth   = depth;
    cur_size    = size;
    msg_words   = (size + 63) / 64;
    bp_dly      = bp;
    abort_words = abort;
    phase = 0; words = 0; hv = 0;
    pad_cnt = 0; blk_cnt = 0; last_cnt = 0; stall_cnt = 0;
    valid_in    = 1'b1;
    block_ready = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL msg timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
    valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b1; block_ready = 1'b0;
    abort_words = -1;
    @(posedge clk);
    #1;
    // Outputs held low under reset even with valid_in high.
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      check("reset_outputs", int'(outv), 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0; valid_in = 1'b0;
    @(negedge clk);
    check("post_reset_idle", int'(outv), 10'b1000000000);
    @(posedge clk);
    #1;

    // SHAKE128, one full word
    build_trace(21, 64, 0);
    check("model_len_128_64", exp_q.size(), 26);
    run_msg(21, 64, 0, -1);
    check("pad_128_64", pad_cnt, 20);
    check("blocks_128_64", blk_cnt, 1);
    check("last_128_64", last_cnt, 1);

    // SHAKE128, second word partial
    build_trace(21, 72, 0);
    check("model_len_128_72", exp_q.size(), 26);
    run_msg(21, 72, 0, -1);
    check("pad_128_72", pad_cnt, 19);

    // SHAKE256, exact block: extra all-padding block
    build_trace(17, 1088, 0);
    check("model_len_256_1088", exp_q.size(), 40);
    run_msg(17, 1088, 0, -1);
    check("pad_256_1088", pad_cnt, 17);
    check("blocks_256_1088", blk_cnt, 2);
    check("last_256_1088", last_cnt, 1);

    // Empty message
    build_trace(17, 0, 0);
    check("model_len_256_0", exp_q.size(), 22);
    run_msg(17, 0, 0, -1);
    check("pad_256_0", pad_cnt, 17);
    check("blocks_256_0", blk_cnt, 1);

    // Backpressure: five stalled handoff cycles
    build_trace(21, 100, 5);
    run_msg(21, 100, 5, -1);
    check("stall_bp", stall_cnt, 5);
    check("pad_bp", pad_cnt, 19);

    // Two blocks with message resuming in LOAD after handoff
    build_trace(21, 1400, 2);
    run_msg(21, 1400, 2, -1);
    check("blocks_128_1400", blk_cnt, 2);
    check("pad_128_1400", pad_cnt, 20);

    // Reset mid-LOAD after 3 words, then a fresh message
    exp_q.push_back(vec(1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) exp_q.push_back(vec(1, 0, 1, 0, 0, 1, 0, 0, 0, 1));
    exp_q.push_back(10'b0);
    exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_msg(17, 640, 0, 3);
    build_trace(17, 640, 0);
    run_msg(17, 640, 0, -1);
    check("pad_after_reset", pad_cnt, 7);
    check("last_after_reset", last_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
